// File: rtl/lstm_pkg.sv
// Shared fixed-point constants and FSM state type for the LSTM matrix-vector datapath.
package lstm_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int Q_FRAC     = 12;
    localparam int PROD_SHIFT = 14;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 32'sd32767;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -32'sd32768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_SAT,
        ST_OUT
    } state_t;

endpackage

// File: rtl/mac4.sv
// Four-lane signed multiply with per-lane arithmetic right shift, summed in 32-bit arithmetic.
module mac4
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] w0,
    input  logic signed [DATA_WIDTH-1:0] w1,
    input  logic signed [DATA_WIDTH-1:0] w2,
    input  logic signed [DATA_WIDTH-1:0] w3,
    input  logic signed [DATA_WIDTH-1:0] x0,
    input  logic signed [DATA_WIDTH-1:0] x1,
    input  logic signed [DATA_WIDTH-1:0] x2,
    input  logic signed [DATA_WIDTH-1:0] x3,
    output logic signed [ACC_WIDTH-1:0]  sum
);

    logic signed [ACC_WIDTH-1:0] p0, p1, p2, p3;

    always_comb begin
        p0  = ACC_WIDTH'(w0) * ACC_WIDTH'(x0);
        p1  = ACC_WIDTH'(w1) * ACC_WIDTH'(x1);
        p2  = ACC_WIDTH'(w2) * ACC_WIDTH'(x2);
        p3  = ACC_WIDTH'(w3) * ACC_WIDTH'(x3);
        // Arithmetic shift floors negative lanes toward minus infinity
        sum = (p0 >>> PROD_SHIFT) + (p1 >>> PROD_SHIFT)
            + (p2 >>> PROD_SHIFT) + (p3 >>> PROD_SHIFT);
    end

endmodule

// File: rtl/matvec_row_seq.sv
// Sequences one matrix row: fetches len 4-element groups, accumulates the lane MACs,
// adds bias, saturates to Q4.12 and holds the result until the consumer accepts it.
module matvec_row_seq
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_GROUPS = 16,
    parameter int ADDR_WIDTH = $clog2(MAX_GROUPS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          len,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic signed [DATA_WIDTH-1:0] w0,
    input  logic signed [DATA_WIDTH-1:0] w1,
    input  logic signed [DATA_WIDTH-1:0] w2,
    input  logic signed [DATA_WIDTH-1:0] w3,
    input  logic signed [DATA_WIDTH-1:0] x0,
    input  logic signed [DATA_WIDTH-1:0] x1,
    input  logic signed [DATA_WIDTH-1:0] x2,
    input  logic signed [DATA_WIDTH-1:0] x3,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         busy,
    output logic                         err_len
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_GROUPS);

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [ADDR_WIDTH:0]          len_q, len_d;
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic signed [DATA_WIDTH-1:0] result_q, result_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  mac_sum;
    logic signed [ACC_WIDTH-1:0]  biased;
    logic                         rd_vld_q, rd_vld_d;
    logic                         result_valid_q, result_valid_d;
    logic                         err_len_q, err_len_d;
    logic                         len_ok;

    function automatic logic signed [DATA_WIDTH-1:0] sat_q412(
        input logic signed [ACC_WIDTH-1:0] v
    );
        if (v > SAT_MAX) begin
            return DATA_WIDTH'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return DATA_WIDTH'(SAT_MIN);
        end else begin
            return DATA_WIDTH'(v);
        end
    endfunction

    mac4 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac4 (
        .w0 (w0),
        .w1 (w1),
        .w2 (w2),
        .w3 (w3),
        .x0 (x0),
        .x1 (x1),
        .x2 (x2),
        .x3 (x3),
        .sum(mac_sum)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        bias_d         = bias_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        err_len_d      = 1'b0;
        rd_en          = 1'b0;
        rd_addr        = '0;
        len_ok         = (len != '0) && (len <= MAX_LEN);
        biased         = acc_q + ACC_WIDTH'(bias_q);

        // Operand data lands one cycle after its fetch strobe
        if (rd_vld_q) begin
            acc_d = acc_q + mac_sum;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = len;
                        bias_d  = bias;
                        acc_d   = '0;
                        addr_d  = '0;
                        state_d = ST_FETCH;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = addr_q;
                if ({1'b0, addr_q} == len_q - (ADDR_WIDTH+1)'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_SAT;
            end
            ST_SAT: begin
                result_d       = sat_q412(biased);
                result_valid_d = 1'b1;
                state_d        = ST_OUT;
            end
            ST_OUT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_vld_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            len_q          <= '0;
            bias_q         <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            rd_vld_q       <= 1'b0;
            err_len_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            bias_q         <= bias_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            rd_vld_q       <= rd_vld_d;
            err_len_q      <= err_len_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err_len      = err_len_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matvec_row_seq.sv
// Directed bench for matvec_row_seq with a one-cycle-latency operand memory model.
module tb_matvec_row_seq;

    localparam int DW = 16;
    localparam int MG = 16;
    localparam int AW = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [AW:0]          len;
    logic signed [DW-1:0] bias;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] w0, w1, w2, w3, x0, x1, x2, x3;
    logic signed [DW-1:0] result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 busy;
    logic                 err_len;

    logic signed [DW-1:0] wm [MG][4];
    logic signed [DW-1:0] xm [MG][4];
    logic [AW-1:0]        paddr;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;

    matvec_row_seq #(
        .DATA_WIDTH(DW),
        .MAX_GROUPS(MG),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .len         (len),
        .bias        (bias),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .w0          (w0),
        .w1          (w1),
        .w2          (w2),
        .w3          (w3),
        .x0          (x0),
        .x1          (x1),
        .x2          (x2),
        .x3          (x3),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy),
        .err_len     (err_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operand memory answers the cycle after each fetch strobe
    always @(posedge clk) paddr <= rd_addr;
    assign w0 = wm[paddr][0];
    assign w1 = wm[paddr][1];
    assign w2 = wm[paddr][2];
    assign w3 = wm[paddr][3];
    assign x0 = xm[paddr][0];
    assign x1 = xm[paddr][1];
    assign x2 = xm[paddr][2];
    assign x3 = xm[paddr][3];

    always @(negedge clk) begin
        if (rd_en === 1'b1) rd_cnt++;
        if (err_len === 1'b1) err_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all(input logic signed [DW-1:0] wv, input logic signed [DW-1:0] xv);
        for (int g = 0; g < MG; g++) begin
            for (int l = 0; l < 4; l++) begin
                wm[g][l] = wv;
                xm[g][l] = xv;
            end
        end
    endtask

    // Group 0 sums to 2560, group 1 to -4097 (includes a -1*1 lane that floors to -1)
    task automatic set_mixed_data;
        fill_all(16'sd0, 16'sd0);
        wm[0][0] = 16'sd4096;  wm[0][1] = 16'sd8192; wm[0][2] = -16'sd4096; wm[0][3] = 16'sd2048;
        xm[0][0] = 16'sd4096;  xm[0][1] = 16'sd4096; xm[0][2] = 16'sd4096;  xm[0][3] = 16'sd4096;
        wm[1][0] = -16'sd8192; wm[1][1] = 16'sd0;    wm[1][2] = 16'sd4096;  wm[1][3] = -16'sd1;
        xm[1][0] = 16'sd4096;  xm[1][1] = 16'sd4096; xm[1][2] = -16'sd8192; xm[1][3] = 16'sd1;
    endtask

    task automatic start_row(input int n, input logic signed [DW-1:0] b);
        start = 1'b1;
        len   = (AW+1)'(n);
        bias  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic accept;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; result_ready = 1'b0; len = '0; bias = '0;
        fill_all(16'sd0, 16'sd0);
        tick();
        tick();
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        checks++; if (rd_addr !== '0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (int'(result) !== 0) begin failures++; $display("FAIL reset_result got=%0d exp=0", int'(result)); end
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL reset_err_len got=%b exp=0", err_len); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unit;
        int cyc;
        int n0;
        fill_all(16'sd4096, 16'sd4096);
        n0 = rd_cnt;
        start_row(1, 16'sd0);
        checks++; if (rd_en !== 1'b1 || rd_addr !== '0) begin failures++; $display("FAIL unit_first_fetch got=%b/%0d exp=1/0", rd_en, rd_addr); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL unit_busy got=%b exp=1", busy); end
        wait_valid(20, cyc);
        checks++; if (cyc !== 3) begin failures++; $display("FAIL unit_latency got=%0d exp=3", cyc); end
        checks++; if (int'(result) !== 4096) begin failures++; $display("FAIL unit_result got=%0d exp=4096", int'(result)); end
        checks++; if (rd_cnt - n0 !== 1) begin failures++; $display("FAIL unit_rd_count got=%0d exp=1", rd_cnt - n0); end
        accept();
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL unit_release got=%b/%b exp=0/0", result_valid, busy); end
    endtask

    task automatic test_pos_sat;
        int cyc;
        int n0;
        fill_all(16'sd32767, 16'sd32767);
        n0 = rd_cnt;
        start_row(16, 16'sd0);
        wait_valid(40, cyc);
        checks++; if (cyc !== 18) begin failures++; $display("FAIL pos_latency got=%0d exp=18", cyc); end
        checks++; if (int'(dut.acc_q) !== 4194048) begin failures++; $display("FAIL pos_acc got=%0d exp=4194048", int'(dut.acc_q)); end
        checks++; if (int'(result) !== 32767) begin failures++; $display("FAIL pos_result got=%0d exp=32767", int'(result)); end
        checks++; if (rd_cnt - n0 !== 16) begin failures++; $display("FAIL pos_rd_count got=%0d exp=16", rd_cnt - n0); end
        accept();
    endtask

    task automatic test_neg_sat;
        int cyc;
        fill_all(-16'sd32767 - 16'sd1, 16'sd32767);
        start_row(16, 16'sd0);
        wait_valid(40, cyc);
        checks++; if (int'(dut.acc_q) !== -4194176) begin failures++; $display("FAIL neg_acc got=%0d exp=-4194176", int'(dut.acc_q)); end
        checks++; if (int'(result) !== -32768) begin failures++; $display("FAIL neg_result got=%0d exp=-32768", int'(result)); end
        accept();
    endtask

    task automatic test_backpressure;
        int cyc;
        int n0;
        set_mixed_data();
        n0 = rd_cnt;
        start_row(2, 16'sd4096);
        wait_valid(20, cyc);
        checks++; if (cyc !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", cyc); end
        checks++; if (int'(dut.acc_q) !== -1537) begin failures++; $display("FAIL bp_acc got=%0d exp=-1537", int'(dut.acc_q)); end
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 5'd1;
            tick();
            checks++; if (int'(result) !== 2559 || result_valid !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d got=%0d/%b/%b exp=2559/1/1", i, int'(result), result_valid, busy);
            end
        end
        checks++; if (rd_cnt - n0 !== 2) begin failures++; $display("FAIL bp_rd_count got=%0d exp=2", rd_cnt - n0); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b exp=0/0", result_valid, busy); end
        tick();
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL bp_start_ignored got=%b/%b exp=0/0", busy, rd_en); end
    endtask

    task automatic test_bad_len;
        int n0;
        int e0;
        n0 = rd_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            len   = (k == 0) ? 5'd0 : 5'(MG + 1);
            tick();
            start = 1'b0;
            checks++; if (err_len !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
                failures++;
                $display("FAIL badlen%0d_pulse got=%b/%b/%b exp=1/0/0", k, err_len, busy, rd_en);
            end
            tick();
            checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL badlen%0d_clear got=%b exp=0", k, err_len); end
        end
        checks++; if (err_cnt - e0 !== 2) begin failures++; $display("FAIL badlen_pulses got=%0d exp=2", err_cnt - e0); end
        checks++; if (rd_cnt - n0 !== 0) begin failures++; $display("FAIL badlen_rd_count got=%0d exp=0", rd_cnt - n0); end
    endtask

    task automatic test_midrun_reset;
        int cyc;
        fill_all(16'sd1000, 16'sd2000);
        start_row(8, 16'sd0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (rd_en !== 1'b0 || rd_addr !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_ctrl got=%b/%0d/%b exp=0/0/0", rd_en, rd_addr, busy);
        end
        checks++; if (result_valid !== 1'b0 || int'(result) !== 0 || err_len !== 1'b0) begin
            failures++;
            $display("FAIL mid_out got=%b/%0d/%b exp=0/0/0", result_valid, int'(result), err_len);
        end
        checks++; if (int'(dut.acc_q) !== 0) begin failures++; $display("FAIL mid_acc got=%0d exp=0", int'(dut.acc_q)); end
        rst_n = 1'b1;
        tick();
        checks++; if (int'(dut.acc_q) !== 0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_discard got=%0d/%b exp=0/0", int'(dut.acc_q), result_valid);
        end
        set_mixed_data();
        start_row(2, 16'sd4096);
        wait_valid(20, cyc);
        checks++; if (cyc !== 4) begin failures++; $display("FAIL mid_rerun_latency got=%0d exp=4", cyc); end
        checks++; if (int'(result) !== 2559) begin failures++; $display("FAIL mid_rerun_result got=%0d exp=2559", int'(result)); end
        accept();
    endtask

    initial begin
        test_reset();
        test_unit();
        test_pos_sat();
        test_neg_sat();
        test_backpressure();
        test_bad_len();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
